// File: rtl/gp_count_sched_pkg.sv
// gp_count_sched_pkg: shared types and limits for the shared down-counter
// scheduler.
//   state_t  - controller state (IDLE, COUNT, HOLD)
//   *_MIN/*_MAX - legal ranges for NREQ, WIDTH and PRESCALE
//   idx_w()  - index width for NREQ requesters, max(1, $clog2(n))
package gp_count_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int NREQ_MIN     = 2;
  localparam int NREQ_MAX     = 8;
  localparam int WIDTH_MIN    = 1;
  localparam int WIDTH_MAX    = 14;
  localparam int PRESCALE_MIN = 1;
  localparam int PRESCALE_MAX = 256;

  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gp_rr_pick.sv
// gp_rr_pick: combinational round-robin picker.
//   req  in  NREQ  request vector
//   ptr  in  IDXW  highest-priority index (must be < NREQ)
//   any  out 1     some request is set
//   idx  out IDXW  first set bit searching upward from ptr, wrapping
module gp_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic            any,
  output logic [IDXW-1:0] idx
);

  // Walk the search order backwards so the lowest distance from ptr is the
  // last (winning) assignment.
  always_comb begin
    any = |req;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) idx = IDXW'((int'(ptr) + k) % NREQ);
    end
  end

endmodule

// File: rtl/gp_count_sched.sv
// gp_count_sched: time-shares one down counter (period COUNT_TO+1 ticks)
// among NREQ one-shot delay requesters with round-robin arbitration.
//   CLK       in   1           clock, rising edge
//   RST       in   1           asynchronous active-high reset
//   REQ       in   NREQ        request levels
//   COUNT_TO  in   NREQ*WIDTH  terminal value per requester, slice i*WIDTH
//   GNT       out  NREQ        one-hot owner
//   DONE      out  NREQ        one-cycle completion pulse to owner
//   BUSY      out  1           controller not idle
//   POUT      out  WIDTH       current count, 0 when idle
module gp_count_sched
  import gp_count_sched_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*WIDTH-1:0] COUNT_TO,
  output logic [NREQ-1:0]       GNT,
  output logic [NREQ-1:0]       DONE,
  output logic                  BUSY,
  output logic [WIDTH-1:0]      POUT
);

  localparam int IDXW = idx_w(NREQ);
  localparam int DIVW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(PRESCALE - 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREQ - 1);

  if (NREQ < NREQ_MIN || NREQ > NREQ_MAX) begin : g_bad_nreq
    $error("gp_count_sched: NREQ out of range");
  end
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("gp_count_sched: WIDTH out of range");
  end
  if (PRESCALE < PRESCALE_MIN || PRESCALE > PRESCALE_MAX) begin : g_bad_prescale
    $error("gp_count_sched: PRESCALE out of range");
  end

  state_t           state;
  logic [IDXW-1:0]  ptr;
  logic [IDXW-1:0]  own;
  logic [IDXW-1:0]  nxt_ptr;
  logic [WIDTH-1:0] cnt;
  logic [DIVW-1:0]  div;
  logic             tick;
  logic             pick_any;
  logic [IDXW-1:0]  pick_idx;

  gp_rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
    .req (REQ),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign tick    = (div == DIV_LAST);
  assign nxt_ptr = (own == LAST_IDX) ? '0 : own + 1'b1;
  // cnt is forced to 0 whenever the controller is idle or holding, so the
  // count register itself is the registered POUT.
  assign POUT    = cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      ptr   <= '0;
      own   <= '0;
      cnt   <= '0;
      div   <= '0;
      GNT   <= '0;
      DONE  <= '0;
      BUSY  <= 1'b0;
    end else begin
      DONE <= '0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            own   <= pick_idx;
            cnt   <= COUNT_TO[int'(pick_idx)*WIDTH +: WIDTH];
            div   <= '0;
            GNT   <= NREQ'(1) << pick_idx;
            BUSY  <= 1'b1;
            state <= COUNT;
          end
        end
        COUNT: begin
          // Cancel wins over a terminal tick on the same edge: no DONE.
          if (!REQ[own]) begin
            state <= IDLE;
            GNT   <= '0;
            BUSY  <= 1'b0;
            cnt   <= '0;
            div   <= '0;
            ptr   <= nxt_ptr;
          end else begin
            div <= tick ? '0 : div + 1'b1;
            if (tick) begin
              if (cnt != '0) begin
                cnt <= cnt - 1'b1;
              end else begin
                DONE[own] <= 1'b1;
                state     <= HOLD;
              end
            end
          end
        end
        HOLD: begin
          if (!REQ[own]) begin
            state <= IDLE;
            GNT   <= '0;
            BUSY  <= 1'b0;
            div   <= '0;
            ptr   <= nxt_ptr;
          end
        end
        default: begin
          state <= IDLE;
          GNT   <= '0;
          BUSY  <= 1'b0;
          cnt   <= '0;
          div   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gp_count_sched.sv
// Bench for gp_count_sched: a transaction-level reference model predicts
// grant/done events (done time = grant + (C+1)*PRESCALE) into a queue that
// a negedge monitor drains; a second narrow-PRESCALE, WIDTH=14 instance is
// exercised with directed latency runs.
module tb_gp_count_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int P     = 4;

  logic                  CLK = 1'b0;
  logic                  RST = 1'b1;
  logic [NREQ-1:0]       req;
  logic [WIDTH-1:0]      to [NREQ];
  logic [NREQ*WIDTH-1:0] count_to;
  logic [NREQ-1:0]       gnt, done;
  logic                  busy;
  logic [WIDTH-1:0]      pout;

  logic [1:0]  w_req;
  logic [27:0] w_count_to;
  logic [1:0]  w_gnt, w_done;
  logic        w_busy;
  logic [13:0] w_pout;

  always #5 CLK = ~CLK;

  always_comb begin
    count_to = '0;
    for (int i = 0; i < NREQ; i++) count_to[i*WIDTH +: WIDTH] = to[i];
  end

  gp_count_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .PRESCALE(P)) dut (
    .CLK(CLK), .RST(RST), .REQ(req), .COUNT_TO(count_to),
    .GNT(gnt), .DONE(done), .BUSY(busy), .POUT(pout)
  );

  gp_count_sched #(.NREQ(2), .WIDTH(14), .PRESCALE(1)) dut_w (
    .CLK(CLK), .RST(RST), .REQ(w_req), .COUNT_TO(w_count_to),
    .GNT(w_gnt), .DONE(w_done), .BUSY(w_busy), .POUT(w_pout)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit is_done;
    int idx;
    int cyc;
  } ev_t;

  ev_t exq[$];
  int  gnt_log[$];
  int  cyc;
  bit  m_busy, m_hold;
  int  m_own, m_ptr, m_c, m_gstart, m_done_at;

  task automatic model_reset();
    m_busy = 0; m_hold = 0; m_own = 0; m_ptr = 0;
    m_c = 0; m_gstart = 0; m_done_at = 0;
  endtask

  initial begin
    int w;
    cyc = 0;
    model_reset();
    forever begin
      @(posedge CLK or posedge RST);
      if (RST) begin
        model_reset();
        exq.delete();
      end else begin
        cyc++;
        if (!m_busy) begin
          w = -1;
          for (int k = 0; k < NREQ; k++)
            if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
          if (w >= 0) begin
            m_busy = 1; m_hold = 0; m_own = w;
            m_c = int'(to[w]);
            m_gstart = cyc;
            m_done_at = cyc + (m_c + 1) * P;
            exq.push_back('{0, w, cyc});
          end
        end else if (!m_hold) begin
          if (!req[m_own]) begin
            m_busy = 0; m_ptr = (m_own + 1) % NREQ;
          end else if (cyc == m_done_at) begin
            m_hold = 1;
            exq.push_back('{1, m_own, cyc});
          end
        end else if (!req[m_own]) begin
          m_busy = 0; m_hold = 0; m_ptr = (m_own + 1) % NREQ;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  task automatic pop_check(input bit is_done);
    ev_t e;
    logic [NREQ-1:0] line;
    line = is_done ? done : gnt;
    if (exq.size() == 0) begin
      chk(is_done ? "spurious_done" : "spurious_gnt", line, 0);
    end else begin
      e = exq.pop_front();
      chk("ev_kind", is_done, e.is_done);
      chk("ev_line", line, 1 << e.idx);
      chk("ev_cycle", cyc, e.cyc);
    end
  endtask

  initial begin
    logic [NREQ-1:0] prev;
    int gi;
    int exp_pout;
    prev = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        prev = '0;
      end else begin
        exp_pout = (m_busy && !m_hold) ? m_c - (cyc - m_gstart) / P : 0;
        chk("busy", busy, m_busy);
        chk("gnt", gnt, m_busy ? (1 << m_own) : 0);
        chk("pout", pout, exp_pout);
        if (gnt != 0 && prev == 0) begin
          gi = 0;
          for (int i = 0; i < NREQ; i++) if (gnt[i]) gi = i;
          gnt_log.push_back(gi);
          pop_check(0);
        end
        if (done != 0) pop_check(1);
        prev = gnt;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while ((busy || m_busy) && n < lim) begin
      step();
      n++;
    end
    chk("idle_reached", busy, 0);
  endtask

  task automatic wide_run(input int c);
    int n, wraps;
    logic [13:0] prev;
    step();
    w_count_to = {14'd0, 14'(c)};
    w_req = 2'b01;
    n = 0;
    while (w_gnt == 0 && n < 10) begin
      @(negedge CLK);
      n++;
    end
    chk("wide_gnt", w_gnt, 2'b01);
    chk("wide_pout_start", w_pout, c);
    prev = w_pout; wraps = 0; n = 0;
    while (!w_done[0] && n < c + 20) begin
      @(negedge CLK);
      n++;
      if (w_pout > prev) wraps++;
      prev = w_pout;
    end
    chk("wide_latency", n, c + 1);
    chk("wide_wrap", wraps, 0);
    chk("wide_pout_end", w_pout, 0);
    w_req = 2'b00;
    @(negedge CLK);
    @(negedge CLK);
    chk("wide_release_busy", w_busy, 0);
    chk("wide_release_gnt", w_gnt, 0);
  endtask

  initial begin
    int n;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    req = '0;
    for (int i = 0; i < NREQ; i++) to[i] = '0;
    w_req = '0;
    w_count_to = '0;

    // reset state
    #12;
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pout", pout, 0);
    chk("rst_wide_busy", w_busy, 0);
    RST = 1'b0;
    step();

    // fairness: all requesting, each releases after DONE and re-requests
    for (int i = 0; i < NREQ; i++) to[i] = 8'd2;
    req = '1;
    gnt_log.delete();
    n = 0;
    while (gnt_log.size() < 5 && n < 400) begin
      step();
      if (m_busy && m_hold) req[m_own] = 1'b0;
      for (int i = 0; i < NREQ; i++)
        if (!req[i] && !(m_busy && m_own == i)) req[i] = 1'b1;
      n++;
    end
    chk("fair_count", gnt_log.size() >= 5, 1);
    for (int k = 0; k < 5; k++)
      if (k < gnt_log.size()) chk("fair_order", gnt_log[k], exp_order[k]);
    req = '0;
    wait_idle(200);

    // single request, COUNT_TO = 5
    to[0] = 8'd5;
    req = 4'b0001;
    n = 0;
    while (!m_hold && n < 100) begin
      step();
      n++;
    end
    req = '0;
    wait_idle(20);

    // cancel racing the terminal tick, then ptr must have advanced past 1
    to[1] = 8'd3;
    req = 4'b0010;
    n = 0;
    while (!(m_busy && !m_hold && cyc + 1 == m_done_at) && n < 100) begin
      step();
      n++;
    end
    req[1] = 1'b0;
    step();
    chk("race_done", done, 0);
    chk("race_busy", busy, 0);
    to[0] = 8'd1;
    to[2] = 8'd1;
    req = 4'b0101;
    step();
    chk("race_ptr", gnt, 4'b0100);
    req = '0;
    wait_idle(50);

    // randomized traffic
    for (int c = 0; c < 2500; c++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 5) == 0) begin
            to[i] = ($urandom_range(0, 19) == 0) ? WIDTH'($urandom_range(0, 60))
                                                  : WIDTH'($urandom_range(0, 5));
            req[i] = 1'b1;
          end
        end else if (m_busy && m_own == i) begin
          if (m_hold) begin
            if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
          end else if (cyc + 1 == m_done_at) begin
            if ($urandom_range(0, 2) == 0) req[i] = 1'b0;
          end else if ($urandom_range(0, 60) == 0) begin
            req[i] = 1'b0;
          end
        end else if ($urandom_range(0, 40) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    req = '0;
    wait_idle(2000);

    // asynchronous reset in the middle of a count
    to[2] = 8'd10;
    req = 4'b0100;
    n = 0;
    while (pout !== 8'd3 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("midrst_reach", pout, 3);
    #2;
    RST = 1'b1;
    #1;
    chk("midrst_gnt", gnt, 0);
    chk("midrst_done", done, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_pout", pout, 0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    n = 0;
    while (gnt == 0 && n < 10) begin
      @(negedge CLK);
      n++;
    end
    chk("midrst_regrant_gnt", gnt, 4'b0100);
    chk("midrst_regrant_pout", pout, 10);
    req = '0;
    wait_idle(50);

    // wide counter: zero, small and full-range terminal values
    wide_run(0);
    wide_run(5);
    wide_run(16383);

    step();
    chk("queue_drained", exq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
